eth_rx_ring_dma: RTL and testbench

//  Parametrised AXI-Stream Ethernet RX DMA engine: lands incoming frames into a ring of

---
 rtl/eth_rx_ring_dma_pkg.sv | 56 +++++
 rtl/eth_rx_ring_dma_credit.sv | 32 +++
 rtl/eth_rx_ring_dma.sv | 193 +++++++++++++++++++
 tb/tb_eth_rx_ring_dma.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_ring_dma_pkg.sv
// Shared types for the Ethernet ring DMA engines: FSM states, control commands, io_cmd header.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package eth_rx_ring_dma_pkg;

  // Processor-side widths used to build the io_cmd header.
  localparam int paddr_width_gp  = 40;
  localparam int lce_id_width_gp = 4;

  typedef enum logic [2:0] {
    e_rx_init    = 3'd0,
    e_rx_empty   = 3'd1,
    e_rx_payload = 3'd2,
    e_rx_drain   = 3'd3,
    e_rx_size    = 3'd4,
    e_rx_sync    = 3'd5
  } eth_rx_state_e;

  typedef enum logic [2:0] {
    e_eth_set_ring_base = 3'b001,
    e_eth_rx_ack        = 3'b010
  } eth_cmd_e;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3
  } bedrock_mem_type_e;

  // Header occupies the low bits of an io_cmd; the data beat sits above it.
  typedef struct packed {
    logic [lce_id_width_gp-1:0] src_id;
    logic [2:0]                 size;
    logic [paddr_width_gp-1:0]  addr;
    bedrock_mem_type_e          msg_type;
  } io_hdr_t;

  // Slot header is at least one 8-byte length word, or one full beat if wider.
  function automatic int hdr_bytes(input int axis_width);
    return (axis_width / 8 > 8) ? axis_width / 8 : 8;
  endfunction

  // BedRock size field is log2 of the byte count.
  function automatic logic [2:0] size_enc(input int nbytes);
    return 3'($clog2(nbytes));
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 64; i++) c = c + 7'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_ring_dma_credit.sv
// Outstanding-write counter: +1 per accepted io_cmd, -1 per io_resp, saturating at both ends.
// Latency: count updates on the clock edge after the event.
// Backpressure: none itself; the parent compares count_o against max_credits_p.
// Ports: clk_i, reset_n_i (async active-low), up_i, down_i, count_o.
module eth_rx_ring_dma_credit #(
  parameter int max_credits_p = 16,
  parameter int count_width_p = $clog2(max_credits_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     up_i,
  input  logic                     down_i,
  output logic [count_width_p-1:0] count_o
);

  localparam logic [count_width_p-1:0] max_lp = count_width_p'(max_credits_p);

  logic [count_width_p-1:0] count_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_r <= '0;
    end else if (up_i && !down_i && count_r != max_lp) begin
      count_r <= count_r + 1'b1;
    end else if (!up_i && down_i && count_r != '0) begin
      count_r <= count_r - 1'b1;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/eth_rx_ring_dma.sv
// AXIS Ethernet RX DMA: lands frames into a ring of fixed slots via uncached-write io_cmds.
// Latency: first payload cmd 1 cycle after tvalid is seen in EMPTY, then 1 cmd/cycle.
// Backpressure: tready follows io_cmd_yumi_i; stalls when ring full or credits exhausted.
// Ports: clk_i/reset_n_i; eth_cmd_* control; rx_axis_* frame input; io_cmd_*/io_resp_* memory
//   side; rx_ext_state_o, rx_slots_used_o, rx_drop_cnt_o, rx_irq_o status.
import eth_rx_ring_dma_pkg::*;

module eth_rx_ring_dma #(
  parameter int axis_data_width_p = 64,
  parameter int reg_addr_width_p  = paddr_width_gp,
  parameter int slots_p           = 4,
  parameter int slot_bytes_p      = 2048,
  parameter int max_credits_p     = 16,
  parameter int eth_cmd_width_p   = 3
) (
  input  logic                                         clk_i,
  input  logic                                         reset_n_i,
  input  logic [lce_id_width_gp-1:0]                   lce_id_i,
  input  logic [eth_cmd_width_p-1:0]                   eth_cmd_i,
  input  logic                                         eth_cmd_v_i,
  input  logic [reg_addr_width_p-1:0]                  eth_cmd_arg_i,
  input  logic [axis_data_width_p-1:0]                 rx_axis_tdata_i,
  input  logic [axis_data_width_p/8-1:0]               rx_axis_tkeep_i,
  input  logic                                         rx_axis_tvalid_i,
  output logic                                         rx_axis_tready_o,
  input  logic                                         rx_axis_tlast_i,
  input  logic                                         rx_axis_tuser_i,
  output logic [$bits(io_hdr_t)+axis_data_width_p-1:0] io_cmd_o,
  output logic                                         io_cmd_v_o,
  input  logic                                         io_cmd_yumi_i,
  input  logic [$bits(io_hdr_t)+axis_data_width_p-1:0] io_resp_i,
  input  logic                                         io_resp_v_i,
  output logic                                         io_resp_ready_o,
  output logic [1:0]                                   rx_ext_state_o,
  output logic [$clog2(slots_p+1)-1:0]                 rx_slots_used_o,
  output logic [15:0]                                  rx_drop_cnt_o,
  output logic                                         rx_irq_o
);

  localparam int axis_bytes_lp = axis_data_width_p / 8;
  localparam int hdr_bytes_lp  = hdr_bytes(axis_data_width_p);
  localparam int slot_w_lp     = $clog2(slots_p);
  localparam int slot_sh_lp    = $clog2(slot_bytes_p);
  localparam int used_w_lp     = $clog2(slots_p + 1);
  localparam int off_w_lp      = slot_sh_lp + 1;
  localparam int cred_w_lp     = $clog2(max_credits_p + 1);

  localparam logic [used_w_lp-1:0] slots_lp    = used_w_lp'(slots_p);
  localparam logic [cred_w_lp-1:0] max_cred_lp = cred_w_lp'(max_credits_p);
  // Largest payload offset whose whole beat still fits behind the length header.
  localparam logic [off_w_lp-1:0]  last_off_lp = off_w_lp'(slot_bytes_p - hdr_bytes_lp - axis_bytes_lp);

  eth_rx_state_e                 state_r, state_n;
  logic [reg_addr_width_p-1:0]   base_r;
  logic [slot_w_lp-1:0]          head_r;
  logic [used_w_lp-1:0]          used_r;
  logic [off_w_lp-1:0]           off_r;
  logic [15:0]                   len_r;
  logic [15:0]                   drop_r;
  logic                          irq_r;
  logic [cred_w_lp-1:0]          credits;

  logic cmd_v, size_sel, accept, drop_inc, commit, tready;
  logic set_ok, ack_ok, cmd_set, cmd_ack;
  logic [reg_addr_width_p-1:0]   slot_addr, cmd_addr;
  logic [axis_data_width_p-1:0]  cmd_data;
  io_hdr_t                       hdr;

  // Write acks carry nothing we need; only io_resp_v_i matters.
  logic unused_resp;
  assign unused_resp = ^io_resp_i;

  eth_rx_ring_dma_credit #(.max_credits_p(max_credits_p)) credit_u (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .up_i     (cmd_v && io_cmd_yumi_i),
    .down_i   (io_resp_v_i),
    .count_o  (credits)
  );

  assign cmd_set = eth_cmd_v_i && (eth_cmd_i == eth_cmd_width_p'(e_eth_set_ring_base));
  assign cmd_ack = eth_cmd_v_i && (eth_cmd_i == eth_cmd_width_p'(e_eth_rx_ack));
  // Moving the base under committed frames would orphan them, so only allow it when drained.
  assign set_ok  = cmd_set && (state_r == e_rx_init || (state_r == e_rx_empty && used_r == '0));
  assign ack_ok  = cmd_ack && state_r != e_rx_init && used_r != '0;

  always_comb begin
    state_n  = state_r;
    tready   = 1'b0;
    cmd_v    = 1'b0;
    size_sel = 1'b0;
    accept   = 1'b0;
    drop_inc = 1'b0;
    commit   = 1'b0;
    case (state_r)
      e_rx_init:  if (set_ok) state_n = e_rx_empty;
      e_rx_empty: if (used_r != slots_lp && rx_axis_tvalid_i) state_n = e_rx_payload;
      e_rx_payload: begin
        if (rx_axis_tvalid_i) begin
          if (rx_axis_tlast_i && rx_axis_tuser_i) begin
            tready   = 1'b1;
            drop_inc = 1'b1;
            state_n  = e_rx_empty;
          end else if (off_r > last_off_lp) begin
            // Overflowing beat is swallowed here; a tlast overflow needs no drain.
            tready   = 1'b1;
            drop_inc = 1'b1;
            state_n  = rx_axis_tlast_i ? e_rx_empty : e_rx_drain;
          end else begin
            cmd_v  = credits < max_cred_lp;
            accept = cmd_v && io_cmd_yumi_i;
            tready = accept;
            if (accept && rx_axis_tlast_i) state_n = e_rx_size;
          end
        end
      end
      e_rx_drain: begin
        tready = 1'b1;
        if (rx_axis_tvalid_i && rx_axis_tlast_i) state_n = e_rx_empty;
      end
      e_rx_size: begin
        cmd_v    = credits < max_cred_lp;
        size_sel = 1'b1;
        if (cmd_v && io_cmd_yumi_i) state_n = e_rx_sync;
      end
      e_rx_sync: begin
        // Commit only once every write of the frame is acknowledged by memory.
        if (credits == '0) begin
          commit  = 1'b1;
          state_n = e_rx_empty;
        end
      end
      default: state_n = e_rx_init;
    endcase
  end

  always_comb begin
    slot_addr    = base_r + reg_addr_width_p'({head_r, {slot_sh_lp{1'b0}}});
    cmd_addr     = size_sel ? slot_addr
                            : slot_addr + reg_addr_width_p'(hdr_bytes_lp) + reg_addr_width_p'(off_r);
    cmd_data     = size_sel ? axis_data_width_p'(len_r) : rx_axis_tdata_i;
    hdr.msg_type = e_bedrock_mem_uc_wr;
    hdr.src_id   = lce_id_i;
    hdr.size     = size_sel ? size_enc(8) : size_enc(axis_bytes_lp);
    hdr.addr     = paddr_width_gp'(cmd_addr);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_rx_init;
      base_r  <= '0;
      head_r  <= '0;
      used_r  <= '0;
      off_r   <= '0;
      len_r   <= '0;
      drop_r  <= '0;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      irq_r   <= commit;
      if (set_ok) begin
        base_r <= eth_cmd_arg_i;
        head_r <= '0;
      end else if (commit) begin
        head_r <= head_r + 1'b1;
      end
      case ({commit, ack_ok})
        2'b10:   used_r <= used_r + 1'b1;
        2'b01:   used_r <= used_r - 1'b1;
        default: used_r <= used_r;
      endcase
      if (state_r == e_rx_empty) begin
        off_r <= '0;
        len_r <= '0;
      end else if (accept) begin
        off_r <= off_r + off_w_lp'(axis_bytes_lp);
        len_r <= len_r + 16'(popcount64(64'(rx_axis_tkeep_i)));
      end
      if (drop_inc && drop_r != 16'hFFFF) drop_r <= drop_r + 16'd1;
    end
  end

  assign io_cmd_v_o       = cmd_v;
  assign io_cmd_o         = cmd_v ? {cmd_data, hdr} : '0;
  assign rx_axis_tready_o = tready;
  // Responses only exist once a ring is configured; holding low in INIT keeps reset outputs at 0.
  assign io_resp_ready_o  = state_r != e_rx_init;
  assign rx_ext_state_o   = (state_r == e_rx_init) ? 2'b00 : (used_r != '0) ? 2'b10 : 2'b01;
  assign rx_slots_used_o  = used_r;
  assign rx_drop_cnt_o    = drop_r;
  assign rx_irq_o         = irq_r;

endmodule

// File: tb/tb_eth_rx_ring_dma.sv
// Directed bench for eth_rx_ring_dma (64b AXIS, 4 x 2048B slots, 16 credits).
// Memory side: yumi follows io_cmd_v, one io_resp per accepted cmd, can be withheld.
// Outputs sampled at negedge or #1 after posedge; inputs driven #1 after posedge.
module tb_eth_rx_ring_dma;
  import eth_rx_ring_dma_pkg::*;

  localparam int HW = $bits(io_hdr_t);
  localparam int MW = HW + 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    lce_id = 4'h5;
  logic [2:0]    eth_cmd = '0;
  logic          eth_cmd_v = 1'b0;
  logic [39:0]   eth_cmd_arg = '0;
  logic [63:0]   tdata = '0;
  logic [7:0]    tkeep = '0;
  logic          tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
  logic          tready;
  logic [MW-1:0] io_cmd;
  logic          io_cmd_v, io_cmd_yumi;
  logic [MW-1:0] io_resp = '0;
  logic          io_resp_v = 1'b0;
  logic          io_resp_ready;
  logic [1:0]    ext_state;
  logic [2:0]    slots_used;
  logic [15:0]   drop_cnt;
  logic          irq;

  eth_rx_ring_dma dut (
    .clk_i(clk), .reset_n_i(reset_n), .lce_id_i(lce_id),
    .eth_cmd_i(eth_cmd), .eth_cmd_v_i(eth_cmd_v), .eth_cmd_arg_i(eth_cmd_arg),
    .rx_axis_tdata_i(tdata), .rx_axis_tkeep_i(tkeep), .rx_axis_tvalid_i(tvalid),
    .rx_axis_tready_o(tready), .rx_axis_tlast_i(tlast), .rx_axis_tuser_i(tuser),
    .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_yumi_i(io_cmd_yumi),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_ready_o(io_resp_ready),
    .rx_ext_state_o(ext_state), .rx_slots_used_o(slots_used),
    .rx_drop_cnt_o(drop_cnt), .rx_irq_o(irq)
  );

  assign io_cmd_yumi = io_cmd_v;

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int irq_cnt = 0;
  int pending = 0;
  logic resp_en = 1'b1;

  logic [39:0] q_addr[$];
  logic [63:0] q_data[$];
  logic [10:0] q_attr[$];   // {msg_type, size, src_id}

  io_hdr_t mon_hdr;
  assign mon_hdr = io_hdr_t'(io_cmd[HW-1:0]);

  // Memory model: log accepted cmds, answer each with one response when enabled.
  initial forever begin
    @(negedge clk);
    if (io_cmd_v && io_cmd_yumi) begin
      q_addr.push_back(mon_hdr.addr);
      q_data.push_back(io_cmd[MW-1:HW]);
      q_attr.push_back({mon_hdr.msg_type, mon_hdr.size, mon_hdr.src_id});
      pending++;
    end
    if (io_resp_v) pending--;
    if (irq) irq_cnt++;
    @(posedge clk); #1;
    if (!reset_n) pending = 0;
    io_resp_v = reset_n && resp_en && pending > 0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    q_addr.delete(); q_data.delete(); q_attr.delete();
  endtask

  task automatic chk_cmd(input string tag, input logic [39:0] a, input logic [2:0] sz, input logic [63:0] d);
    if (q_addr.size() == 0) begin
      chk({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_addr"}, 64'(q_addr.pop_front()), 64'(a));
      chk({tag, "_data"}, q_data.pop_front(), d);
      chk({tag, "_attr"}, 64'(q_attr.pop_front()), 64'({4'd3, sz, 4'h5}));
    end
  endtask

  task automatic ctl(input logic [2:0] c, input logic [39:0] arg);
    eth_cmd = c; eth_cmd_arg = arg; eth_cmd_v = 1'b1;
    @(posedge clk); #1;
    eth_cmd_v = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    logic ok;
    tdata = d; tkeep = k; tlast = l; tuser = u; tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = tready;
      @(posedge clk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = '0;
    if (!ok) chk("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input int f, input int n, input logic [7:0] last_keep, input logic bad);
    for (int b = 0; b < n; b++)
      send_beat({32'(f), 32'(b)}, (b == n - 1) ? last_keep : 8'hFF, b == n - 1, bad && (b == n - 1));
  endtask

  task automatic wait_irq(input int target);
    for (int i = 0; i < 300 && irq_cnt < target; i++) begin
      @(posedge clk); #1;
    end
    chk("irq_count", 64'(irq_cnt), 64'(target));
  endtask

  task automatic stall_check(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (tready || io_cmd_v) seen = 1'b1;
    end
    @(posedge clk); #1;
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(tready), 0);
    chk("rst_cmd_v", 64'(io_cmd_v), 0);
    chk("rst_cmd", 64'(io_cmd), 0);
    chk("rst_ext", 64'(ext_state), 0);
    chk("rst_used", 64'(slots_used), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    chk("rst_irq", 64'(irq), 0);
    chk("rst_resp_rdy", 64'(io_resp_ready), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Configure ring, land a 3-beat frame of 20 bytes
    ctl(3'b001, 40'h8000);
    chk("cfg_ext", 64'(ext_state), 64'd1);
    chk("cfg_resp_rdy", 64'(io_resp_ready), 64'd1);
    clr_q();
    send_frame(1, 3, 8'h0F, 1'b0);
    wait_irq(1);
    chk_cmd("f1b0", 40'h8008, 3'd3, {32'd1, 32'd0});
    chk_cmd("f1b1", 40'h8010, 3'd3, {32'd1, 32'd1});
    chk_cmd("f1b2", 40'h8018, 3'd3, {32'd1, 32'd2});
    chk_cmd("f1len", 40'h8000, 3'd3, 64'd20);
    chk("f1_ext", 64'(ext_state), 64'd2);
    chk("f1_used", 64'(slots_used), 64'd1);

    // Fill remaining slots
    for (int f = 2; f <= 4; f++) begin
      clr_q();
      send_frame(f, 1, 8'hFF, 1'b0);
      wait_irq(f);
    end
    chk_cmd("f4b0", 40'h9808, 3'd3, {32'd4, 32'd0});
    chk_cmd("f4len", 40'h9800, 3'd3, 64'd8);
    chk("full_used", 64'(slots_used), 64'd4);
    ctl(3'b001, 40'hF000);   // must be ignored while slots are in use

    // Fifth frame stalls until one ACK
    clr_q();
    tdata = {32'd5, 32'd0}; tkeep = 8'hFF; tlast = 1'b1; tvalid = 1'b1;
    stall_check("full_stall");
    chk("full_no_cmd", 64'(q_addr.size()), 64'd0);
    ctl(3'b010, 40'h0);
    send_beat({32'd5, 32'd0}, 8'hFF, 1'b1, 1'b0);
    wait_irq(5);
    chk_cmd("f5b0", 40'h8008, 3'd3, {32'd5, 32'd0});
    chk_cmd("f5len", 40'h8000, 3'd3, 64'd8);
    chk("f5_used", 64'(slots_used), 64'd4);
    repeat (4) ctl(3'b010, 40'h0);
    chk("acked_used", 64'(slots_used), 64'd0);
    chk("acked_ext", 64'(ext_state), 64'd1);
    ctl(3'b010, 40'h0);
    chk("ack_at_zero", 64'(slots_used), 64'd0);

    // Bad frame (tuser on tlast) is dropped, slot 1 reused
    clr_q();
    send_frame(6, 2, 8'hFF, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("bad_drop", 64'(drop_cnt), 64'd1);
    chk("bad_no_irq", 64'(irq_cnt), 64'd5);
    chk_cmd("f6b0", 40'h8808, 3'd3, {32'd6, 32'd0});
    chk("bad_qempty", 64'(q_addr.size()), 64'd0);
    send_frame(7, 1, 8'hFF, 1'b0);
    wait_irq(6);
    chk_cmd("f7b0", 40'h8808, 3'd3, {32'd7, 32'd0});
    chk_cmd("f7len", 40'h8800, 3'd3, 64'd8);
    ctl(3'b010, 40'h0);

    // 2100-byte frame overflows slot 2, then a 64-byte frame reuses it
    clr_q();
    send_frame(8, 263, 8'h0F, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_drop", 64'(drop_cnt), 64'd2);
    chk("ovf_no_irq", 64'(irq_cnt), 64'd6);
    chk("ovf_ncmd", 64'(q_addr.size()), 64'd255);
    chk("ovf_first", 64'(q_addr[0]), 64'h9008);
    chk("ovf_last", 64'(q_addr[254]), 64'h97F8);
    clr_q();
    send_frame(9, 8, 8'hFF, 1'b0);
    wait_irq(7);
    chk("f9_ncmd", 64'(q_addr.size()), 64'd9);
    chk("f9_b7", 64'(q_addr[7]), 64'h9040);
    chk("f9_len_addr", 64'(q_addr[8]), 64'h9000);
    chk("f9_len", q_data[8], 64'd64);
    chk("f9_used", 64'(slots_used), 64'd1);

    // Credit throttling with responses withheld
    clr_q();
    resp_en = 1'b0;
    for (int b = 0; b < 16; b++) send_beat({32'd10, 32'(b)}, 8'hFF, 1'b0, 1'b0);
    tdata = {32'd10, 32'd16}; tkeep = 8'hFF; tvalid = 1'b1;
    stall_check("credit_stall");
    chk("credit_ncmd", 64'(q_addr.size()), 64'd16);
    resp_en = 1'b1;
    for (int b = 16; b < 20; b++) send_beat({32'd10, 32'(b)}, 8'hFF, b == 19, 1'b0);
    wait_irq(8);
    chk("f10_ncmd", 64'(q_addr.size()), 64'd21);
    chk("f10_b19", 64'(q_addr[19]), 64'h98A0);
    chk("f10_len_addr", 64'(q_addr[20]), 64'h9800);
    chk("f10_len", q_data[20], 64'd160);
    chk("f10_used", 64'(slots_used), 64'd2);

    // Reset in the middle of a frame
    clr_q();
    send_beat({32'd11, 32'd0}, 8'hFF, 1'b0, 1'b0);
    tdata = {32'd11, 32'd1}; tkeep = 8'hFF; tvalid = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cmd_v", 64'(io_cmd_v), 0);
    chk("mid_rst_tready", 64'(tready), 0);
    chk("mid_rst_ext", 64'(ext_state), 0);
    chk("mid_rst_used", 64'(slots_used), 0);
    chk("mid_rst_drop", 64'(drop_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stall_check("no_ring_stall");
    ctl(3'b010, 40'h0);
    chk("init_ack_ext", 64'(ext_state), 0);
    chk("init_ack_used", 64'(slots_used), 0);
    tvalid = 1'b0;
    ctl(3'b001, 40'h10000);
    chk("restart_ext", 64'(ext_state), 64'd1);
    clr_q();
    send_frame(12, 1, 8'hFF, 1'b0);
    wait_irq(9);
    chk_cmd("f12b0", 40'h10008, 3'd3, {32'd12, 32'd0});
    chk_cmd("f12len", 40'h10000, 3'd3, 64'd8);
    chk("f12_used", 64'(slots_used), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
